// File: rtl/output_port_demux.sv
// Output port demultiplexer: fans a single packet stream out to NUM_QUEUES output
// queues using the one-hot destination in the IOQ header; bad packets are dropped.
module output_port_demux #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int                    NUM_QUEUES = 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL   = 8'hFF,
  parameter int                    DST_POS    = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [NUM_QUEUES-1:0] out_wr,
  input  logic [NUM_QUEUES-1:0] out_rdy,
  output logic                  pkt_fwd,
  output logic                  pkt_drop
);

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [CTRL_WIDTH-1:0] mem_ctrl [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;

  state_t                state_q;
  logic [NUM_QUEUES-1:0] dst_mask_q;
  logic [CTRL_WIDTH-1:0] prev_ctrl_q;

  logic                  empty, full, push, pop;
  logic                  is_eop, ports_rdy;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [NUM_QUEUES-1:0] hdr_mask;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign in_rdy    = (count_q < (AW+1)'(3));
  assign push      = in_wr && !full;
  assign head_data = mem_data[rd_ptr_q];
  assign head_ctrl = mem_ctrl[rd_ptr_q];
  assign hdr_mask  = head_data[DST_POS +: NUM_QUEUES];
  // A nonzero ctrl directly after a zero-ctrl word marks the last word of a packet.
  assign is_eop    = (prev_ctrl_q == '0) && (head_ctrl != '0);
  assign ports_rdy = &(out_rdy | ~dst_mask_q);
  assign pop       = !empty && (((state_q == FWD) && ports_rdy) || (state_q == DROP));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_ctrl[wr_ptr_q] <= in_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dst_mask_q  <= '0;
      prev_ctrl_q <= CTRL_WIDTH'(1);
      out_wr      <= '0;
      out_data    <= '0;
      out_ctrl    <= CTRL_WIDTH'(1);
      pkt_fwd     <= 1'b0;
      pkt_drop    <= 1'b0;
    end else begin
      out_wr   <= '0;
      pkt_fwd  <= 1'b0;
      pkt_drop <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Decide on the header without consuming it; it is popped in FWD/DROP.
          if (!empty) begin
            if ((head_ctrl == IOQ_CTRL) && (hdr_mask != '0)) begin
              dst_mask_q <= hdr_mask;
              state_q    <= FWD;
            end else begin
              state_q <= DROP;
            end
          end
        end
        FWD: begin
          if (pop) begin
            out_wr   <= dst_mask_q;
            out_data <= head_data;
            out_ctrl <= head_ctrl;
            if (is_eop) begin
              pkt_fwd     <= 1'b1;
              state_q     <= IDLE;
              prev_ctrl_q <= CTRL_WIDTH'(1);
            end else begin
              prev_ctrl_q <= head_ctrl;
            end
          end
        end
        DROP: begin
          if (pop) begin
            if (is_eop) begin
              pkt_drop    <= 1'b1;
              state_q     <= IDLE;
              prev_ctrl_q <= CTRL_WIDTH'(1);
            end else begin
              prev_ctrl_q <= head_ctrl;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_demux.sv
// Directed bench for output_port_demux with a packet-level scoreboard model and
// hand-computed timing/sequence expectations.
module tb_output_port_demux;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NQ = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_wr;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NQ-1:0] out_wr;
  logic [NQ-1:0] out_rdy;
  logic          pkt_fwd;
  logic          pkt_drop;

  always #5 clk = ~clk;

  output_port_demux dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .pkt_fwd(pkt_fwd), .pkt_drop(pkt_drop)
  );

  typedef struct packed {logic [NQ-1:0] mask; logic [CW-1:0] ctrl; logic [DW-1:0] data;} beat_t;
  typedef struct packed {logic [CW-1:0] ctrl; logic [DW-1:0] data;} word_t;

  word_t         stim_q[$];
  beat_t         exp_q[$];
  bit            ev_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [NQ-1:0] rdy_at_edge;
  int            log_cyc[$];
  logic [NQ-1:0] log_mask[$];
  logic [CW-1:0] log_ctrl[$];
  int            fwd_cyc[$];
  int            drop_cyc[$];
  int            rel, stall_port, stall_from, stall_to;
  int            n_pushed, first_push_cyc;
  bit            saw_rdy_low;
  beat_t         e_cur;
  bit            ev_cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rdy_at_edge = out_rdy;
  end

  // Scoreboard: every strobe must match the next expected beat, only when the
  // whole destination set was ready at the edge that produced it.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_wr != '0) begin
        log_cyc.push_back(cyc);
        log_mask.push_back(out_wr);
        log_ctrl.push_back(out_ctrl);
        if (exp_q.size() == 0) chk("unexpected_wr", 64'(out_wr), 64'd0);
        else begin
          e_cur = exp_q.pop_front();
          chk("out_wr", 64'(out_wr), 64'(e_cur.mask));
          chk("out_ctrl", 64'(out_ctrl), 64'(e_cur.ctrl));
          chk("out_data", out_data, e_cur.data);
        end
        chk("wr_while_ready", 64'(&(rdy_at_edge | ~out_wr)), 64'd1);
      end
      if (pkt_fwd || pkt_drop) begin
        if (pkt_fwd) fwd_cyc.push_back(cyc);
        if (pkt_drop) drop_cyc.push_back(cyc);
        if (ev_q.size() == 0) chk("unexpected_pulse", 64'({pkt_fwd, pkt_drop}), 64'd0);
        else begin
          ev_cur = ev_q.pop_front();
          chk("pkt_pulse", 64'({pkt_fwd, pkt_drop}), ev_cur ? 64'd2 : 64'd1);
        end
      end
    end
  end

  // Packet model: forwarded iff header ctrl is FF and the low NQ dst bits are nonzero.
  task automatic send_pkt(input logic [CW-1:0] hctrl, input logic [DW-1:0] hdata,
                          input int nwords, input logic [CW-1:0] last_ctrl, input int seed);
    word_t         w;
    beat_t         b;
    logic [NQ-1:0] mask;
    bit            fwd;
    mask = hdata[48 +: NQ];
    fwd  = (hctrl == 8'hFF) && (mask != '0);
    for (int i = 0; i < nwords; i++) begin
      if (i == 0) begin
        w.ctrl = hctrl; w.data = hdata;
      end else begin
        w.ctrl = (i == nwords - 1) ? last_ctrl : 8'h00;
        w.data = 64'hD000_0000_0000_0000 | (64'(seed) << 16) | 64'(i);
      end
      stim_q.push_back(w);
      if (fwd) begin
        b.mask = mask; b.ctrl = w.ctrl; b.data = w.data;
        exp_q.push_back(b);
      end
    end
    ev_q.push_back(fwd);
  endtask

  task automatic step();
    word_t w;
    @(negedge clk);
    rel++;
    if (stall_port >= 0) out_rdy[stall_port] = !(rel >= stall_from && rel <= stall_to);
    if (!in_rdy) saw_rdy_low = 1'b1;
    if (stim_q.size() > 0 && in_rdy && !reset) begin
      w = stim_q.pop_front();
      in_data = w.data;
      in_ctrl = w.ctrl;
      in_wr   = 1'b1;
      if (n_pushed == 0) first_push_cyc = cyc + 1;
      n_pushed++;
    end else begin
      in_wr = 1'b0;
    end
  endtask

  task automatic start_test();
    log_cyc.delete(); log_mask.delete(); log_ctrl.delete();
    fwd_cyc.delete(); drop_cyc.delete();
    rel = 0; n_pushed = 0; saw_rdy_low = 1'b0;
    stall_port = -1; out_rdy = '1;
  endtask

  task automatic run_test(input string name, input int maxc);
    int n;
    n = 0;
    while ((stim_q.size() + exp_q.size() + ev_q.size()) != 0 && n < maxc) begin
      step();
      n++;
    end
    repeat (4) step();
    chk({name, "_drained"}, 64'(stim_q.size() + exp_q.size() + ev_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0; out_rdy = '1;
    stall_port = -1;
    repeat (3) @(negedge clk);
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd1);
    chk("rst_pulses", 64'({pkt_fwd, pkt_drop}), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    reset = 1'b0;

    // Unicast, 4 words to port 2
    start_test();
    send_pkt(8'hFF, 64'h0004_0000_0000_1111, 4, 8'h08, 1);
    run_test("unicast", 60);
    chk("uc_beats", 64'(log_cyc.size()), 64'd4);
    chk("uc_latency", 64'(log_cyc[0] - first_push_cyc), 64'd2);
    chk("uc_contiguous", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
    chk("uc_mask", 64'(log_mask[0]), 64'h04);
    chk("uc_ctrl0", 64'(log_ctrl[0]), 64'hFF);
    chk("uc_ctrl1", 64'(log_ctrl[1]), 64'h00);
    chk("uc_ctrl2", 64'(log_ctrl[2]), 64'h00);
    chk("uc_ctrl3", 64'(log_ctrl[3]), 64'h08);
    chk("uc_fwd_count", 64'(fwd_cyc.size()), 64'd1);
    chk("uc_fwd_with_eop", 64'(fwd_cyc[0]), 64'(log_cyc[3]));

    // Multicast to ports 0 and 2, port 2 stalls after the header
    start_test();
    stall_port = 2; stall_from = 4; stall_to = 6;
    send_pkt(8'hFF, 64'h0005_0000_0000_2222, 5, 8'h10, 2);
    run_test("mcast", 80);
    chk("mc_beats", 64'(log_cyc.size()), 64'd5);
    chk("mc_mask", 64'(log_mask[1]), 64'h05);
    chk("mc_stall_gap", 64'(log_cyc[1] - log_cyc[0]), 64'd4);
    chk("mc_in_rdy_low", 64'(saw_rdy_low), 64'd1);

    // Zero destination (only an out-of-range dst bit), then a good packet
    start_test();
    send_pkt(8'hFF, 64'h0100_0000_0000_3333, 3, 8'h04, 3);
    send_pkt(8'hFF, 64'h0008_0000_0000_4444, 3, 8'h02, 4);
    run_test("dropzero", 80);
    chk("dz_drop_count", 64'(drop_cyc.size()), 64'd1);
    chk("dz_fwd_count", 64'(fwd_cyc.size()), 64'd1);
    chk("dz_beats", 64'(log_cyc.size()), 64'd3);
    chk("dz_mask", 64'(log_mask[0]), 64'h08);

    // Malformed header ctrl
    start_test();
    send_pkt(8'h01, 64'h0004_0000_0000_5555, 3, 8'h08, 5);
    run_test("malformed", 60);
    chk("mf_drop_count", 64'(drop_cyc.size()), 64'd1);
    chk("mf_fwd_count", 64'(fwd_cyc.size()), 64'd0);
    chk("mf_beats", 64'(log_cyc.size()), 64'd0);

    // Back-to-back packets to port 0 then port 7
    start_test();
    send_pkt(8'hFF, 64'h0001_0000_0000_6666, 3, 8'h01, 6);
    send_pkt(8'hFF, 64'h0080_0000_0000_7777, 3, 8'h01, 7);
    run_test("b2b", 80);
    chk("bb_beats", 64'(log_cyc.size()), 64'd6);
    chk("bb_mask_a", 64'(log_mask[2]), 64'h01);
    chk("bb_mask_b", 64'(log_mask[3]), 64'h80);
    chk("bb_idle_gap", 64'(log_cyc[3] - log_cyc[2]), 64'd2);
    chk("bb_fwd_count", 64'(fwd_cyc.size()), 64'd2);

    // Asynchronous reset in the middle of a forwarded packet
    start_test();
    send_pkt(8'hFF, 64'h0002_0000_0000_8888, 5, 8'h01, 8);
    n = 0;
    while (out_wr == '0 && n < 30) begin step(); n++; end
    chk("rm_started", 64'(out_wr != '0), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rm_out_wr_cleared", 64'(out_wr), 64'd0);
    chk("rm_out_ctrl_reset", 64'(out_ctrl), 64'd1);
    stim_q.delete(); exp_q.delete(); ev_q.delete();
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rm_in_rdy", 64'(in_rdy), 64'd1);
    start_test();
    send_pkt(8'hFF, 64'h0010_0000_0000_9999, 4, 8'h20, 9);
    run_test("after_reset", 60);
    chk("ar_beats", 64'(log_cyc.size()), 64'd4);
    chk("ar_mask", 64'(log_mask[0]), 64'h10);
    chk("ar_fwd_count", 64'(fwd_cyc.size()), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
